rot_quad_gen: RTL and testbench

ROT_QUAD_GEN -- requirements
Module: rot_quad_gen

---
 rtl/rot_quad_gen.sv | 165 ++++++++++++++++
 tb/tb_rot_quad_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_quad_gen.sv
// rot_quad_gen
// Emits rotary-encoder style quadrature steps on rot_A/rot_B from a small
// queue of left/right step commands. Each step walks the four quadrature
// phases, holding each phase for PHASE_CYCLES clocks. The outputs rest at 00
// (the detent position) when idle.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   step_valid  step command offered this cycle
//   step_left   direction of offered step (1 = left, 0 = right)
//   step_ready  queue can accept a command this cycle
//   rot_A       quadrature channel A (registered)
//   rot_B       quadrature channel B (registered)
//   busy        a step waveform is being emitted
//   pending     number of queued steps that have not started yet
module rot_quad_gen #(
  parameter int unsigned PHASE_CYCLES = 1000,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_valid,
  input  logic                     step_left,
  output logic                     step_ready,
  output logic                     rot_A,
  output logic                     rot_B,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   phase_cnt_reg, phase_cnt_next;
  logic            dir_left_reg, dir_left_next;
  logic [1:0]      code_reg, code_next;      // {rot_B, rot_A}

  logic [DEPTH-1:0] queue_reg;               // one direction bit per slot
  logic [AW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg;

  logic push;
  logic pop;
  logic phase_done;
  logic head_left;

  // A full queue refuses a push even when the sequencer pops on the same
  // edge; this keeps step_ready a pure function of the registered count.
  assign step_ready = (count_reg != FULL_COUNT);
  assign push       = step_valid && step_ready;
  assign head_left  = queue_reg[head_reg];
  assign phase_done = (phase_cnt_reg == PHASE_LAST);

  // ---------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        queue_reg[tail_reg] <= step_left;
        tail_reg            <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer: next state, pop request and phase counter
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    dir_left_next  = dir_left_reg;
    pop            = 1'b0;
    phase_cnt_next = phase_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop           = 1'b1;
          dir_left_next = head_left;
          state_next    = PH1;
        end
      end
      PH1: if (phase_done) state_next = PH2;
      PH2: if (phase_done) state_next = PH3;
      PH3: if (phase_done) state_next = PH4;
      PH4: begin
        if (phase_done) begin
          // Chain straight into the next queued step so back-to-back
          // steps show no extra rest period beyond PH4 itself.
          if (count_reg != '0) begin
            pop           = 1'b1;
            dir_left_next = head_left;
            state_next    = PH1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The counter restarts on every phase change and rests at zero in IDLE.
    if ((state_next != state_reg) || (state_reg == IDLE)) begin
      phase_cnt_next = '0;
    end
  end

  // Output pattern for the state being entered, so rot_A/rot_B change on the
  // same edge as the state register.
  always_comb begin
    code_next = 2'b00;
    case (state_next)
      PH1:     code_next = dir_left_next ? 2'b10 : 2'b01;
      PH2:     code_next = 2'b11;
      PH3:     code_next = dir_left_next ? 2'b01 : 2'b10;
      default: code_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      dir_left_reg  <= 1'b0;
      code_reg      <= 2'b00;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      dir_left_reg  <= dir_left_next;
      code_reg      <= code_next;
    end
  end

  assign rot_A   = code_reg[0];
  assign rot_B   = code_reg[1];
  assign busy    = (state_reg != IDLE);
  assign pending = count_reg;

endmodule

// File: tb/tb_rot_quad_gen.sv
// Testbench for rot_quad_gen with PHASE_CYCLES = 4, DEPTH = 4.
// A table of single-step vectors is replayed cycle by cycle, followed by
// hand-written sequences for back-to-back steps, push/pop on the same edge,
// reset in mid-step and commands offered while the queue is full. A small
// quadrature decoder model turns the outputs into rlrot events.
module tb_rot_quad_gen;

  localparam int PC = 4;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_valid = 1'b0;
  logic       step_left = 1'b0;
  logic       step_ready;
  logic       rot_A;
  logic       rot_B;
  logic       busy;
  logic [2:0] pending;

  int checks = 0;
  int failures = 0;

  logic [1:0] ev_q[$];   // decoded rlrot events

  always #5 clk = ~clk;

  rot_quad_gen #(
    .PHASE_CYCLES(PC),
    .DEPTH(DP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .step_valid(step_valid),
    .step_left(step_left),
    .step_ready(step_ready),
    .rot_A(rot_A),
    .rot_B(rot_B),
    .busy(busy),
    .pending(pending)
  );

  typedef struct packed {
    logic       left;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] p3;
    logic [1:0] p4;
    logic [1:0] rl;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Quadrature pattern {B,A} for phase index 0..3 of a step.
  function automatic logic [1:0] ph_code(input logic left, input int ph);
    case (ph)
      0:       return left ? 2'b10 : 2'b01;
      1:       return 2'b11;
      2:       return left ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Decoder model: a detent-to-detent walk 00->01->..->10->00 is a right
  // event (10), 00->10->..->01->00 is a left event (11); anything else is
  // recorded as 00. Also checks that only one channel changes per edge.
  initial begin : monitor
    logic [1:0] prev_code;
    logic [1:0] cur_code;
    logic [1:0] start_code;
    prev_code  = 2'b00;
    start_code = 2'b00;
    forever begin
      @(negedge clk);
      cur_code = {rot_B, rot_A};
      if (!rst_n) begin
        prev_code  = 2'b00;
        start_code = 2'b00;
      end else begin
        if (cur_code != prev_code) begin
          checks++;
          if ((cur_code[0] != prev_code[0]) && (cur_code[1] != prev_code[1])) begin
            failures++;
            $display("FAIL gray_step actual=%b->%b required=one channel change", prev_code, cur_code);
          end
          if (prev_code == 2'b00) begin
            start_code = cur_code;
          end else if (cur_code == 2'b00) begin
            if (start_code == 2'b01 && prev_code == 2'b10)      ev_q.push_back(2'b10);
            else if (start_code == 2'b10 && prev_code == 2'b01) ev_q.push_back(2'b11);
            else                                                ev_q.push_back(2'b00);
          end
        end
        prev_code = cur_code;
      end
    end
  end

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((busy || pending != 3'd0) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy || pending != 3'd0) begin
      failures++;
      $display("FAIL %s_idle_timeout actual=busy%0b_pending%0d required=idle", name, busy, pending);
    end
    @(posedge clk); #1;
  endtask

  // exp packs event i at bits [2i+1:2i].
  task automatic chk_events(input string name, input int n, input logic [9:0] exp);
    chk($sformatf("%s_event_count", name), ev_q.size(), n);
    for (int i = 0; i < n && i < ev_q.size(); i++) begin
      chk($sformatf("%s_event%0d", name, i), ev_q[i], exp[2*i +: 2]);
    end
  endtask

  task automatic run_single(input int idx, input vec_t v);
    logic [1:0] pat[4];
    logic [1:0] exp_code;
    pat[0] = v.p1; pat[1] = v.p2; pat[2] = v.p3; pat[3] = v.p4;
    ev_q.delete();
    step_valid = 1'b1;
    step_left  = v.left;
    @(posedge clk); #1;
    step_valid = 1'b0;
    chk($sformatf("v%0d_pending_after_accept", idx), pending, 3'd1);
    chk($sformatf("v%0d_busy_after_accept", idx), busy, 1'b0);
    chk($sformatf("v%0d_code_after_accept", idx), {rot_B, rot_A}, 2'b00);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      exp_code = (k <= 16) ? pat[(k - 1) / 4] : 2'b00;
      chk($sformatf("v%0d_code_c%0d", idx, k), {rot_B, rot_A}, exp_code);
      chk($sformatf("v%0d_busy_c%0d", idx, k), busy, (k <= 16));
    end
    @(posedge clk); #1;
    chk_events($sformatf("v%0d", idx), 1, {8'h00, v.rl});
    $display("single step %0d left=%0b events=%0d", idx, v.left, ev_q.size());
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [4:0]  dirs;
    logic [1:0]  exp_code;
    logic        active;

    vecs[0] = '{left: 1'b0, p1: 2'b01, p2: 2'b11, p3: 2'b10, p4: 2'b00, rl: 2'b10};
    vecs[1] = '{left: 1'b1, p1: 2'b10, p2: 2'b11, p3: 2'b01, p4: 2'b00, rl: 2'b11};
    vecs[2] = '{left: 1'b1, p1: 2'b10, p2: 2'b11, p3: 2'b01, p4: 2'b00, rl: 2'b11};
    vecs[3] = '{left: 1'b0, p1: 2'b01, p2: 2'b11, p3: 2'b10, p4: 2'b00, rl: 2'b10};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_code", {rot_B, rot_A}, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_pending", pending, 3'd0);
    chk("reset_ready", step_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");

    // Table-driven single steps
    for (int i = 0; i < 4; i++) begin
      run_single(i, vecs[i]);
    end

    // Back-to-back: valid held 8 clocks alternating R,L,...; 5 accepted.
    ev_q.delete();
    dirs = 5'b01010;   // bit j = direction of accepted step j
    for (int k = 0; k <= 81; k++) begin
      if (k < 8) begin
        step_valid = 1'b1;
        step_left  = k[0];
        chk($sformatf("b2b_ready_k%0d", k), step_ready, (k < 5));
      end else begin
        step_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        exp_code = (k <= 80) ? ph_code(dirs[(k - 1) / 16], ((k - 1) % 16) / 4) : 2'b00;
        chk($sformatf("b2b_code_k%0d", k), {rot_B, rot_A}, exp_code);
        chk($sformatf("b2b_busy_k%0d", k), busy, (k <= 80));
      end
      if (k == 7) chk("b2b_pending_full", pending, 3'd4);
    end
    @(posedge clk); #1;
    chk_events("b2b", 5, 10'b10_11_10_11_10);
    $display("back-to-back sequence events=%0d", ev_q.size());

    // Push and pop on the same edge with pending = 2.
    ev_q.delete();
    for (int k = 0; k <= 17; k++) begin
      step_valid = (k < 3) || (k == 17);
      step_left  = (k == 1) || (k == 17);
      if (k == 17) chk("pp_pending_before", pending, 3'd2);
      @(posedge clk); #1;
      step_valid = 1'b0;
      if (k == 2) chk("pp_pending_setup", pending, 3'd2);
      if (k == 17) begin
        chk("pp_pending_after", pending, 3'd2);
        chk("pp_code_second_step", {rot_B, rot_A}, 2'b10);
      end
    end
    wait_idle(100, "pp");
    chk_events("pp", 4, 10'b00_11_10_11_10);
    $display("push-pop same edge events=%0d", ev_q.size());

    // Reset during PH2 with 3 pending.
    ev_q.delete();
    for (int k = 0; k < 4; k++) begin
      step_valid = 1'b1;
      step_left  = k[0];
      @(posedge clk); #1;
    end
    step_valid = 1'b0;
    chk("rst_pending_before", pending, 3'd3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_code_in_ph2", {rot_B, rot_A}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_code", {rot_B, rot_A}, 2'b00);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_pending", pending, 3'd0);
    chk("rst_async_ready", step_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    active = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if ({rot_B, rot_A} != 2'b00 || busy || pending != 3'd0) active = 1'b1;
    end
    chk("rst_no_activity_after_release", active, 1'b0);
    chk("rst_no_events", ev_q.size(), 0);
    $display("reset mid-step sequence done");

    // Offers while full are ignored, including on the edge that pops.
    ev_q.delete();
    for (int k = 0; k <= 17; k++) begin
      step_valid = 1'b1;
      step_left  = k[0];
      chk($sformatf("full_ready_k%0d", k), step_ready, (k < 5));
      @(posedge clk); #1;
      if (k == 6) chk("full_pending_hold", pending, 3'd4);
    end
    step_valid = 1'b0;
    chk("full_pending_after_pop", pending, 3'd3);
    wait_idle(120, "full");
    chk_events("full", 5, 10'b10_11_10_11_10);
    $display("full queue sequence events=%0d", ev_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
